// File: rtl/adder_sweep_if.sv
// adder_sweep_if: bundles the operand/sum exchange and the result flags
// between adder_sweep_tester and the logic around it.
// master = the tester, slave = the surrounding top level / adders.
interface adder_sweep_if #(
   parameter int WIDTH         = 14,
   parameter int ERR_CNT_WIDTH = 8
);
   logic                     start;
   logic [WIDTH-1:0]         operand_a;
   logic [WIDTH-1:0]         operand_b;
   logic [WIDTH:0]           dut_sum;
   logic [WIDTH:0]           ref_sum;
   logic                     busy;
   logic                     done;
   logic                     test_fail;
   logic [ERR_CNT_WIDTH-1:0] err_count;
   logic [WIDTH-1:0]         first_fail_a;
   logic [WIDTH-1:0]         first_fail_b;

   modport master (
      input  start, dut_sum, ref_sum,
      output operand_a, operand_b, busy, done, test_fail, err_count,
             first_fail_a, first_fail_b
   );

   modport slave (
      output start, dut_sum, ref_sum,
      input  operand_a, operand_b, busy, done, test_fail, err_count,
             first_fail_a, first_fail_b
   );
endinterface

// File: rtl/adder_sweep_tester.sv
// adder_sweep_tester: drives one operand pair per clock into a DUT adder and
// a golden adder, compares both sums in the same cycle and records a sticky
// fail flag, a saturating error count and the first failing pair.
// SWEEP_MODE 0 walks all 2^(2*WIDTH) pairs; SWEEP_MODE 1 walks NUM_VECTORS
// pairs taken from a 32-bit Galois LFSR.
// Optional build macro ADDER_TESTER_STOP_ON_FAIL_EN: the first mismatch ends
// the sweep with the operands frozen on the failing pair.
module adder_sweep_tester #(
   parameter int          WIDTH         = 14,
   parameter int          SWEEP_MODE    = 0,
   parameter int unsigned NUM_VECTORS   = 4096,
   parameter int          ERR_CNT_WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   adder_sweep_if.master bus
);

`ifdef ADDER_TESTER_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   // Index of the final vector; the 33-bit index keeps 2^32-1 exact at WIDTH=16.
   localparam logic [32:0] LAST_IDX = (SWEEP_MODE == 0)
      ? 33'((64'd1 << (2 * WIDTH)) - 64'd1)
      : 33'(NUM_VECTORS) - 33'd1;

   localparam logic [31:0]              LFSR_SEED = 32'hACE12024;
   localparam logic [31:0]              LFSR_TAPS = 32'h80200003;
   localparam logic [32:0]              IDX_ONE   = 33'd1;
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE   = ERR_CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                   state;
   logic [32:0]              vec_idx;
   logic [31:0]              lfsr;
   logic [WIDTH-1:0]         op_a;
   logic [WIDTH-1:0]         op_b;
   logic                     busy_q;
   logic                     done_q;
   logic                     fail_q;
   logic [ERR_CNT_WIDTH-1:0] err_q;
   logic [WIDTH-1:0]         ffail_a;
   logic [WIDTH-1:0]         ffail_b;

   logic                     mismatch;
   logic [31:0]              lfsr_next;
   logic [WIDTH-1:0]         first_a;
   logic [WIDTH-1:0]         first_b;
   logic [WIDTH-1:0]         next_a;
   logic [WIDTH-1:0]         next_b;

   // Both adders are combinational, so the sums belong to the current operands.
   assign mismatch  = (bus.dut_sum != bus.ref_sum);

   // One right-shift step of the Galois LFSR.
   assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0);

   if (SWEEP_MODE == 0) begin : g_exhaustive
      localparam logic [2*WIDTH-1:0] PAIR_ONE = (2*WIDTH)'(1);
      logic [2*WIDTH-1:0] pair_next;

      // {a,b} as one counter: b is the low half, so a steps when b wraps.
      assign pair_next        = {op_a, op_b} + PAIR_ONE;
      assign first_a          = '0;
      assign first_b          = '0;
      assign {next_a, next_b} = pair_next;
   end else begin : g_lfsr
      assign first_a = LFSR_SEED[WIDTH-1:0];
      assign first_b = LFSR_SEED[WIDTH+15:16];
      assign next_a  = lfsr_next[WIDTH-1:0];
      assign next_b  = lfsr_next[WIDTH+15:16];
   end

   // Sweep FSM: sequences vectors, accumulates results, drives registered outputs.
   // NOTE: all state here uses <= so every register samples pre-edge values;
   // e.g. the first-fail capture sees fail_q as it was before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         vec_idx <= '0;
         lfsr    <= '0;
         op_a    <= '0;
         op_b    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
         err_q   <= '0;
         ffail_a <= '0;
         ffail_b <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state   <= RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  vec_idx <= '0;
                  lfsr    <= LFSR_SEED;
                  op_a    <= first_a;
                  op_b    <= first_b;
                  fail_q  <= 1'b0;
                  err_q   <= '0;
                  ffail_a <= '0;
                  ffail_b <= '0;
               end
            end
            RUN: begin
               if (mismatch) begin
                  fail_q <= 1'b1;
                  if (err_q != '1) err_q <= err_q + ERR_ONE;
                  if (!fail_q) begin
                     ffail_a <= op_a;
                     ffail_b <= op_b;
                  end
               end
               if ((STOP_ON_FAIL && mismatch) || (vec_idx == LAST_IDX)) begin
                  // Operands are left on the last (or failing) vector.
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  vec_idx <= vec_idx + IDX_ONE;
                  lfsr    <= lfsr_next;
                  op_a    <= next_a;
                  op_b    <= next_b;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.operand_a    = op_a;
   assign bus.operand_b    = op_b;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.test_fail    = fail_q;
   assign bus.err_count    = err_q;
   assign bus.first_fail_a = ffail_a;
   assign bus.first_fail_b = ffail_b;

endmodule

// File: tb/tb_adder_sweep_tester.sv
// tb_adder_sweep_tester: directed checks of adder_sweep_tester with three
// instances (WIDTH=3 exhaustive, WIDTH=5 exhaustive with inverted DUT,
// WIDTH=8 LFSR with 100 vectors). Expectations follow the build macro
// ADDER_TESTER_STOP_ON_FAIL_EN.
module tb_adder_sweep_tester;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   fault3   = 0;   // 0 correct, 1 wrong only at a=5,b=2, 2 wrong everywhere
   int   cyc;
   logic [31:0] m;
   logic [7:0]  last_a;
   logic [7:0]  last_b;

   always #5 clk = ~clk;

   adder_sweep_if #(.WIDTH(3), .ERR_CNT_WIDTH(8)) i3 ();
   adder_sweep_if #(.WIDTH(5), .ERR_CNT_WIDTH(8)) i5 ();
   adder_sweep_if #(.WIDTH(8), .ERR_CNT_WIDTH(8)) i8 ();

   adder_sweep_tester #(.WIDTH(3), .SWEEP_MODE(0), .NUM_VECTORS(4096), .ERR_CNT_WIDTH(8))
      u_w3 (.clk(clk), .rst(rst), .bus(i3));
   adder_sweep_tester #(.WIDTH(5), .SWEEP_MODE(0), .NUM_VECTORS(4096), .ERR_CNT_WIDTH(8))
      u_w5 (.clk(clk), .rst(rst), .bus(i5));
   adder_sweep_tester #(.WIDTH(8), .SWEEP_MODE(1), .NUM_VECTORS(100), .ERR_CNT_WIDTH(8))
      u_w8 (.clk(clk), .rst(rst), .bus(i8));

   // Adder models around each tester.
   logic [3:0] sum3;
   assign sum3       = {1'b0, i3.operand_a} + {1'b0, i3.operand_b};
   assign i3.ref_sum = sum3;
   assign i3.dut_sum = (fault3 == 2) ? (sum3 ^ 4'd1) :
                       ((fault3 == 1) && (i3.operand_a == 3'd5) && (i3.operand_b == 3'd2))
                          ? (sum3 ^ 4'd1) : sum3;
   assign i5.ref_sum = {1'b0, i5.operand_a} + {1'b0, i5.operand_b};
   assign i5.dut_sum = ~i5.ref_sum;
   assign i8.ref_sum = {1'b0, i8.operand_a} + {1'b0, i8.operand_b};
   assign i8.dut_sum = i8.ref_sum;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Pulse start on the WIDTH=3 tester and count the cycles busy stays high.
   task automatic run3(input int restart_at, output int cycles);
      i3.start = 1'b1;
      @(negedge clk);
      i3.start = 1'b0;
      check("w3_first_busy", i3.busy, 1);
      check("w3_first_done", i3.done, 0);
      check("w3_first_a", i3.operand_a, 0);
      check("w3_first_b", i3.operand_b, 0);
      check("w3_first_fail_clear", i3.test_fail, 0);
      check("w3_first_err_clear", i3.err_count, 0);
      cycles = 0;
      while (i3.busy && cycles < 1000) begin
         cycles++;
         i3.start = (cycles == restart_at);
         @(negedge clk);
      end
      i3.start = 1'b0;
      check("w3_sweep_bounded", cycles < 1000, 1);
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
   endfunction

   initial begin
      i3.start = 1'b0;
      i5.start = 1'b0;
      i8.start = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", i3.busy, 0);
      check("rst_done", i3.done, 0);
      check("rst_fail", i3.test_fail, 0);
      check("rst_err", i3.err_count, 0);
      check("rst_a", i3.operand_a, 0);
      check("rst_b", i3.operand_b, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", i3.busy, 0);
      check("idle_done", i3.done, 0);

      // Clean exhaustive sweep, WIDTH=3
      fault3 = 0;
      run3(0, cyc);
      check("clean_cycles", cyc, 64);
      check("clean_done", i3.done, 1);
      check("clean_fail", i3.test_fail, 0);
      check("clean_err", i3.err_count, 0);
      check("clean_last_a", i3.operand_a, 7);
      check("clean_last_b", i3.operand_b, 7);

      // Single faulty pair a=5,b=2 (vector index 42), restarted from DONE
      fault3 = 1;
      run3(0, cyc);
`ifdef ADDER_TESTER_STOP_ON_FAIL_EN
      check("pair_cycles", cyc, 43);
      check("pair_frozen_a", i3.operand_a, 5);
      check("pair_frozen_b", i3.operand_b, 2);
`else
      check("pair_cycles", cyc, 64);
      check("pair_last_a", i3.operand_a, 7);
`endif
      check("pair_done", i3.done, 1);
      check("pair_fail", i3.test_fail, 1);
      check("pair_err", i3.err_count, 1);
      check("pair_ffa", i3.first_fail_a, 5);
      check("pair_ffb", i3.first_fail_b, 2);

      // start during RUN ignored; start from DONE clears the old failure
      fault3 = 0;
      run3(10, cyc);
      check("restart_ignored_cycles", cyc, 64);
      check("restart_fail", i3.test_fail, 0);
      check("restart_err", i3.err_count, 0);
      check("restart_ffa", i3.first_fail_a, 0);

      // Asynchronous reset at vector 20 while every vector fails
      fault3 = 2;
      i3.start = 1'b1;
      @(negedge clk);
      i3.start = 1'b0;
      repeat (20) @(negedge clk);
`ifdef ADDER_TESTER_STOP_ON_FAIL_EN
      check("mid_err", i3.err_count, 1);
`else
      check("mid_err", i3.err_count, 20);
      check("mid_a", i3.operand_a, 2);
      check("mid_b", i3.operand_b, 4);
`endif
      #2 rst = 1'b1;
      #1;
      check("async_busy", i3.busy, 0);
      check("async_done", i3.done, 0);
      check("async_fail", i3.test_fail, 0);
      check("async_err", i3.err_count, 0);
      check("async_a", i3.operand_a, 0);
      check("async_b", i3.operand_b, 0);
      check("async_ffa", i3.first_fail_a, 0);
      check("async_ffb", i3.first_fail_b, 0);
      @(negedge clk);
      rst = 1'b0;
      fault3 = 0;
      @(negedge clk);
      run3(0, cyc);
      check("post_rst_cycles", cyc, 64);
      check("post_rst_err", i3.err_count, 0);

      // WIDTH=5, inverted DUT: saturating error count
      i5.start = 1'b1;
      @(negedge clk);
      i5.start = 1'b0;
      check("inv_fail_v0", i5.test_fail, 0);
      cyc = 1;
      @(negedge clk);
      check("inv_fail_v1", i5.test_fail, 1);
      check("inv_err_v1", i5.err_count, 1);
      while (i5.busy && cyc < 5000) begin
         cyc++;
         @(negedge clk);
      end
`ifdef ADDER_TESTER_STOP_ON_FAIL_EN
      check("inv_cycles", cyc, 1);
      check("inv_err", i5.err_count, 1);
`else
      check("inv_cycles", cyc, 1024);
      check("inv_err", i5.err_count, 255);
`endif
      check("inv_done", i5.done, 1);
      check("inv_ffa", i5.first_fail_a, 0);
      check("inv_ffb", i5.first_fail_b, 0);

      // WIDTH=8, LFSR mode, 100 vectors
      m = 32'hACE12024;
      i8.start = 1'b1;
      @(negedge clk);
      i8.start = 1'b0;
      check("lfsr_first_a", i8.operand_a, 8'h24);
      check("lfsr_first_b", i8.operand_b, 8'hE1);
      cyc = 0;
      last_a = '0;
      last_b = '0;
      while (i8.busy && cyc < 1000) begin
         cyc++;
         check("lfsr_vec_a", i8.operand_a, m[7:0]);
         check("lfsr_vec_b", i8.operand_b, m[23:16]);
         last_a = m[7:0];
         last_b = m[23:16];
         m = lfsr_step(m);
         @(negedge clk);
      end
      check("lfsr_cycles", cyc, 100);
      check("lfsr_done", i8.done, 1);
      check("lfsr_err", i8.err_count, 0);
      check("lfsr_fail", i8.test_fail, 0);
      check("lfsr_hold_a", i8.operand_a, last_a);
      check("lfsr_hold_b", i8.operand_b, last_b);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
